// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg: shared types and default tables for the 68000 bus controller.
//   state_t      - controller states (3-bit)
//   DEF_CS_*     - default chip-select region tables (region 0 = boot ROM)
//   cs_field()   - pulls field i of width w out of a packed table
package bus_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    ACK  = 3'd2,
    EXT  = 3'd3,
    BERR = 3'd4,
    AVEC = 3'd5
  } state_t;

  localparam int NUM_CS_DEF = 4;

  localparam logic [NUM_CS_DEF*8-1:0] DEF_CS_BASE = {8'h00, 8'h3E, 8'h3C, 8'h38};
  localparam logic [NUM_CS_DEF*8-1:0] DEF_CS_MASK = {8'h00, 8'hFE, 8'hFE, 8'hFC};
  localparam logic [NUM_CS_DEF*4-1:0] DEF_CS_WAIT = {4'd0, 4'd2, 4'd0, 4'd1};
  localparam logic [NUM_CS_DEF-1:0]   DEF_CS_EXT  = 4'b0100;

  // Field i (width w <= 8) of a packed table, zero-extended to 8 bits.
  // Tables are handed in widened to 256 bits so one function serves all.
  function automatic logic [7:0] cs_field(input logic [255:0] vec, input int i,
                                          input int w);
    logic [7:0] mask;
    mask = (8'd1 << w) - 8'd1;
    return 8'(vec >> (i * w)) & mask;
  endfunction

endpackage

// File: rtl/bus_ctrl_region_match.sv
// bus_ctrl_region_match: combinational priority decoder for chip-select regions.
//   addr  - CPU A[23:16]
//   boot  - 1 = overlay off; 0 forces region 0 regardless of address
//   hit   - one-hot winning region (all zero when nothing matches)
//   win   - index of the winning region
//   any   - some region won
module bus_ctrl_region_match import bus_ctrl_pkg::*; #(
  parameter int NUM_CS = 4,
  parameter logic [NUM_CS*8-1:0] CS_BASE = DEF_CS_BASE,
  parameter logic [NUM_CS*8-1:0] CS_MASK = DEF_CS_MASK,
  localparam int IDX_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic [7:0]        addr,
  input  logic              boot,
  output logic [NUM_CS-1:0] hit,
  output logic [IDX_W-1:0]  win,
  output logic              any
);

  logic [NUM_CS-1:0] raw;

  for (genvar i = 0; i < NUM_CS; i++) begin : g_cmp
    localparam logic [7:0] B = cs_field(256'(CS_BASE), i, 8);
    localparam logic [7:0] M = cs_field(256'(CS_MASK), i, 8);
    assign raw[i] = ((addr ^ B) & M) == 8'h00;
  end

  // Scan from the top down so the lowest matching index is the last write.
  always_comb begin
    hit = '0;
    win = '0;
    any = 1'b0;
    if (!boot) begin
      hit[0] = 1'b1;
      any    = 1'b1;
    end else begin
      for (int i = NUM_CS - 1; i >= 0; i--) begin
        if (raw[i]) begin
          hit    = '0;
          hit[i] = 1'b1;
          win    = IDX_W'(i);
          any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_ctrl.sv
// bus_ctrl: parametrised 68000 bus controller.
//   CLK, RST      - clock shared with CPU; synchronous active-low reset
//   AS, IACK      - CPU address strobe / interrupt acknowledge (active-low)
//   ADDR          - CPU A[23:16]
//   DTACK_IN      - external DTACK from peripherals (active-low)
//   CS            - chip selects (active-low, at most one low)
//   DTACK, BERR   - to CPU (active-low)
//   VPA           - valid peripheral address (active-low)
//   BOOT          - 1 = boot-ROM overlay off
// Build option: define BUS_CTRL_AUTOVEC_EN to answer IACK cycles with VPA
// (autovector) instead of routing them through DTACK_IN.
module bus_ctrl import bus_ctrl_pkg::*; #(
  parameter int NUM_CS       = 4,
  parameter int BOOT_CYCLES  = 8,
  parameter logic [NUM_CS*8-1:0] CS_BASE = DEF_CS_BASE,
  parameter logic [NUM_CS*8-1:0] CS_MASK = DEF_CS_MASK,
  parameter logic [NUM_CS*4-1:0] CS_WAIT = DEF_CS_WAIT,
  parameter logic [NUM_CS-1:0]   CS_EXT  = DEF_CS_EXT,
  parameter int BERR_TIMEOUT = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              AS,
  input  logic              IACK,
  input  logic [7:0]        ADDR,
  input  logic              DTACK_IN,
  output logic [NUM_CS-1:0] CS,
  output logic              DTACK,
  output logic              BERR,
  output logic              VPA,
  output logic              BOOT
);

  localparam int IDX_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int TCNT_W = $clog2(BERR_TIMEOUT);
  localparam int BCNT_W = $clog2(BOOT_CYCLES + 1);

  state_t state, nxt;
  logic [3:0]        wcnt;
  logic [TCNT_W-1:0] tcnt;
  logic [BCNT_W-1:0] bcnt;
  logic              boot_q, dtack_q, berr_q;

  logic [NUM_CS-1:0] hit;
  logic [IDX_W-1:0]  win;
  logic              hit_any;
  logic [3:0]        wait_tbl [NUM_CS];
  logic              timeout;

  bus_ctrl_region_match #(
    .NUM_CS  (NUM_CS),
    .CS_BASE (CS_BASE),
    .CS_MASK (CS_MASK)
  ) u_match (
    .addr (ADDR),
    .boot (boot_q),
    .hit  (hit),
    .win  (win),
    .any  (hit_any)
  );

  for (genvar i = 0; i < NUM_CS; i++) begin : g_wait
    localparam logic [7:0] WF = cs_field(256'(CS_WAIT), i, 4);
    assign wait_tbl[i] = WF[3:0];
  end

  assign timeout = tcnt == TCNT_W'(BERR_TIMEOUT - 1);

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (!AS) begin
        if (!IACK || !hit_any || CS_EXT[win]) nxt = EXT;
        else                                  nxt = WAIT;
`ifdef BUS_CTRL_AUTOVEC_EN
        if (!IACK) nxt = AVEC;
`endif
      end
      // Completion is checked before the watchdog: DTACK beats a
      // same-edge timeout.
      WAIT: if (AS)              nxt = IDLE;
            else if (wcnt == 4'd0) nxt = ACK;
            else if (timeout)      nxt = bus_ctrl_pkg::BERR;
      EXT:  if (AS)                    nxt = IDLE;
            else if (DTACK_IN && timeout) nxt = bus_ctrl_pkg::BERR;
      AVEC: if (AS)           nxt = IDLE;
            else if (timeout) nxt = bus_ctrl_pkg::BERR;
      ACK, bus_ctrl_pkg::BERR: if (AS) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= IDLE;
      wcnt    <= '0;
      tcnt    <= '0;
      bcnt    <= '0;
      boot_q  <= 1'b0;
      dtack_q <= 1'b1;
      berr_q  <= 1'b1;
    end else begin
      state   <= nxt;
      dtack_q <= (nxt != ACK);
      berr_q  <= (nxt != bus_ctrl_pkg::BERR);
      if (state == IDLE) begin
        tcnt <= '0;
        if (!AS) begin
          wcnt <= wait_tbl[win];
          if (bcnt != BCNT_W'(BOOT_CYCLES)) bcnt <= bcnt + BCNT_W'(1);
        end else if (bcnt == BCNT_W'(BOOT_CYCLES)) begin
          boot_q <= 1'b1;
        end
      end else begin
        if (state == WAIT && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
        // Hold at the terminal count so a long external DTACK cannot wrap it.
        if ((state == WAIT || state == EXT || state == AVEC) && !timeout)
          tcnt <= tcnt + TCNT_W'(1);
      end
    end
  end

`ifdef BUS_CTRL_AUTOVEC_EN
  logic vpa_q;
  // VPA starts one edge after the cycle start, hence requiring both the
  // current and next state to be AVEC.
  always_ff @(posedge CLK) begin
    if (!RST) vpa_q <= 1'b1;
    else      vpa_q <= !(state == AVEC && nxt == AVEC);
  end
  assign VPA = vpa_q;
`else
  assign VPA = 1'b1;
`endif

  assign CS    = (!RST || AS || !IACK) ? '1 : ~hit;
  assign DTACK = (state == EXT) ? DTACK_IN : dtack_q;
  assign BERR  = berr_q;
  assign BOOT  = boot_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// tb_bus_ctrl: randomized self-checking bench for bus_ctrl. Expected outputs
// come from a clock-count model: region table lookup, "DTACK after W+1
// clocks", "BERR at 64 clocks", boot counting of cycle starts.
module tb_bus_ctrl;

  localparam int NCS     = 4;
  localparam int BOOT_N  = 8;
  localparam int TIMEOUT = 64;
  localparam int K_WAIT  = 0;
  localparam int K_EXT   = 1;
  localparam int K_AVEC  = 2;

  int base_t [NCS] = '{8'h38, 8'h3C, 8'h3E, 8'h00};
  int mask_t [NCS] = '{8'hFC, 8'hFE, 8'hFE, 8'h00};
  int wait_t [NCS] = '{1, 0, 2, 0};
  int ext_t  [NCS] = '{0, 0, 1, 0};

  logic           CLK = 1'b0;
  logic           RST, AS, IACK, DTACK_IN;
  logic [7:0]     ADDR;
  logic [NCS-1:0] CS;
  logic           DTACK, BERR, VPA, BOOT;

  int n_cmp = 0;
  int n_err = 0;
  int boot_cnt = 0;
  logic boot_m = 1'b0;

  bus_ctrl dut (
    .CLK(CLK), .RST(RST), .AS(AS), .IACK(IACK), .ADDR(ADDR),
    .DTACK_IN(DTACK_IN), .CS(CS), .DTACK(DTACK), .BERR(BERR), .VPA(VPA),
    .BOOT(BOOT)
  );

  always #5 CLK = ~CLK;

  // One bus cycle: AS low for `hold` clocks after the start edge, DTACK_IN
  // low from the dt_delay'th edge onward (-1 = never), then AS released.
  task automatic do_cycle(input logic [7:0] a, input logic iack, input int hold,
                          input int dt_delay, input string tag);
    int idx;
    bit found, berr_m;
    int kind, w;
    logic [NCS-1:0] cs_exp;
    logic exp_dt, exp_vpa;
    found = 0; idx = 0; w = 0; berr_m = 0;
    if (!boot_m) begin
      found = 1; idx = 0;
    end else begin
      for (int i = NCS - 1; i >= 0; i--)
        if (((a ^ 8'(base_t[i])) & 8'(mask_t[i])) == 8'h00) begin
          found = 1; idx = i;
        end
    end
    cs_exp = '1;
    if (iack && found) cs_exp[idx] = 1'b0;
    if (!iack) begin
`ifdef BUS_CTRL_AUTOVEC_EN
      kind = K_AVEC;
`else
      kind = K_EXT;
`endif
    end else if (!found || ext_t[idx] != 0) kind = K_EXT;
    else begin
      kind = K_WAIT; w = wait_t[idx];
    end

    ADDR = a; IACK = iack; AS = 1'b0;
    DTACK_IN = (dt_delay == 0) ? 1'b0 : 1'b1;
    #1;
    n_cmp++;
    if (CS !== cs_exp) begin
      n_err++; $display("FAIL %s pre-edge CS got %b exp %b", tag, CS, cs_exp);
    end
    @(posedge CLK);
    if (boot_cnt < BOOT_N) boot_cnt++;
    for (int e = 0; e < hold; e++) begin
      if (e > 0) begin
        @(posedge CLK);
        if (kind != K_WAIT && !berr_m && e >= TIMEOUT && (kind == K_AVEC || DTACK_IN))
          berr_m = 1;
      end
      @(negedge CLK);
      if (kind == K_WAIT)     exp_dt = (e >= w + 1) ? 1'b0 : 1'b1;
      else if (kind == K_EXT) exp_dt = berr_m ? 1'b1 : DTACK_IN;
      else                    exp_dt = 1'b1;
      exp_vpa = (kind == K_AVEC && e >= 1 && !berr_m) ? 1'b0 : 1'b1;
      n_cmp += 5;
      if (CS !== cs_exp) begin
        n_err++; $display("FAIL %s e=%0d CS got %b exp %b", tag, e, CS, cs_exp);
      end
      if (DTACK !== exp_dt) begin
        n_err++; $display("FAIL %s e=%0d DTACK got %b exp %b", tag, e, DTACK, exp_dt);
      end
      if (BERR !== !berr_m) begin
        n_err++; $display("FAIL %s e=%0d BERR got %b exp %b", tag, e, BERR, !berr_m);
      end
      if (VPA !== exp_vpa) begin
        n_err++; $display("FAIL %s e=%0d VPA got %b exp %b", tag, e, VPA, exp_vpa);
      end
      if (BOOT !== boot_m) begin
        n_err++; $display("FAIL %s e=%0d BOOT got %b exp %b", tag, e, BOOT, boot_m);
      end
      DTACK_IN = (dt_delay >= 0 && e + 1 >= dt_delay) ? 1'b0 : 1'b1;
    end
    AS = 1'b1; DTACK_IN = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    n_cmp += 4;
    if (DTACK !== 1'b1) begin
      n_err++; $display("FAIL %s end DTACK got %b exp 1", tag, DTACK);
    end
    if (BERR !== 1'b1) begin
      n_err++; $display("FAIL %s end BERR got %b exp 1", tag, BERR);
    end
    if (VPA !== 1'b1) begin
      n_err++; $display("FAIL %s end VPA got %b exp 1", tag, VPA);
    end
    if (CS !== '1) begin
      n_err++; $display("FAIL %s end CS got %b exp 1111", tag, CS);
    end
    @(posedge CLK);
    if (boot_cnt == BOOT_N) boot_m = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (BOOT !== boot_m) begin
      n_err++; $display("FAIL %s idle BOOT got %b exp %b", tag, BOOT, boot_m);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; AS = 1'b0; IACK = 1'b1; DTACK_IN = 1'b1; ADDR = 8'($urandom);
    @(negedge CLK);
    n_cmp++;
    if (CS !== '1) begin
      n_err++; $display("FAIL reset_cs got %b exp 1111", CS);
    end
    @(posedge CLK);
    @(negedge CLK);
    n_cmp += 4;
    if (DTACK !== 1'b1) begin n_err++; $display("FAIL reset_dtack got %b exp 1", DTACK); end
    if (BERR !== 1'b1)  begin n_err++; $display("FAIL reset_berr got %b exp 1", BERR); end
    if (VPA !== 1'b1)   begin n_err++; $display("FAIL reset_vpa got %b exp 1", VPA); end
    if (BOOT !== 1'b0)  begin n_err++; $display("FAIL reset_boot got %b exp 0", BOOT); end
    // Mid-cycle reset: region 0 would acknowledge on edge 2; reset at edge 1.
    AS = 1'b1; RST = 1'b1;
    @(negedge CLK);
    ADDR = 8'h38; AS = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      n_cmp += 3;
      if (DTACK !== 1'b1) begin n_err++; $display("FAIL midreset_dtack k=%0d got %b exp 1", k, DTACK); end
      if (CS !== '1)      begin n_err++; $display("FAIL midreset_cs k=%0d got %b exp 1111", k, CS); end
      if (BERR !== 1'b1)  begin n_err++; $display("FAIL midreset_berr k=%0d got %b exp 1", k, BERR); end
    end
    AS = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    boot_cnt = 0; boot_m = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_boot();
    for (int n = 0; n < BOOT_N; n++)
      do_cycle((n % 2 == 0) ? 8'h38 : 8'($urandom), 1'b1, 4, -1, "boot_read");
    n_cmp++;
    if (BOOT !== 1'b1) begin
      n_err++; $display("FAIL boot_after8 got %b exp 1", BOOT);
    end
    do_cycle(8'h10, 1'b1, 3, -1, "boot_9th");
  endtask

  task automatic test_zero_wait();
    do_cycle(8'h3C, 1'b1, 4, -1, "zero_wait");
    do_cycle(8'h3D, 1'b1, 2, -1, "zero_wait_b");
  endtask

  task automatic test_ext();
    do_cycle(8'h3E, 1'b1, 10, 5, "ext_dtack");
  endtask

  task automatic test_timeout();
    do_cycle(8'h3E, 1'b1, 70, -1, "ext_timeout");
    do_cycle(8'h3F, 1'b1, 66, 64, "ext_dtack_at_timeout");
  endtask

  task automatic test_abort();
    do_cycle(8'h39, 1'b1, 1, -1, "abort_wait");
    do_cycle(8'h3A, 1'b1, 4, -1, "after_abort");
  endtask

  task automatic test_iack();
    do_cycle(8'h38, 1'b0, 6, 3, "iack");
    do_cycle(8'h3C, 1'b0, 67, -1, "iack_timeout");
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 4))
        0: a = 8'h38 | 8'($urandom_range(0, 3));
        1: a = 8'h3C | 8'($urandom_range(0, 1));
        2: a = 8'h3E | 8'($urandom_range(0, 1));
        default: a = 8'($urandom);
      endcase
      do_cycle(a, ($urandom_range(0, 4) != 0), $urandom_range(1, 8),
               $urandom_range(0, 7) - 1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_zero_wait();
    test_ext();
    test_timeout();
    test_abort();
    test_iack();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
